// File: rtl/rf_sort_sequencer_pkg.sv
// rf_sort_sequencer_pkg
// Shared constants, the sequencer state encoding and a small length helper
// used by the register-file sort sequencer and its compare unit.
//   RF_DEPTH  : default number of register-file entries
//   RF_WIDTH  : default data width of one register-file entry
//   LEN_W     : width of the requested window length
//   SWAPS_W   : width of the swap counter (worst case 28 swaps for 8 entries)
package rf_sort_sequencer_pkg;

    localparam int RF_DEPTH = 8;
    localparam int RF_WIDTH = 4;
    localparam int LEN_W    = 4;
    localparam int SWAPS_W  = 5;

    // Sequencer states: one read issue, one compare, and two write cycles
    // when a pair has to be exchanged.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CMP,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    // A window can never be longer than the register file itself, so longer
    // requests are cut down to the file depth.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] limit);
        return (len > limit) ? limit : len;
    endfunction

endpackage

// File: rtl/rf_sort_cmp.sv
// rf_sort_cmp
// Combinational order check for one adjacent pair of register-file entries.
// Ports:
//   a, b        : the lower-addressed and higher-addressed entry values
//   descending  : 0 = the pair should end up ascending, 1 = descending
//   swap        : 1 when the pair is out of order and must be exchanged
// The comparison is unsigned, and equal values never request an exchange so
// the sort stays stable and terminates on runs of identical data.
module rf_sort_cmp
    import rf_sort_sequencer_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             descending,
    output logic             swap
);

    // Strict comparisons only, so equal values always stay where they are.
    always_comb begin
        swap = 1'b0;
        if (descending) begin
            swap = (a < b);
        end else begin
            swap = (a > b);
        end
    end

endmodule

// File: rtl/rf_sort_sequencer.sv
// rf_sort_sequencer
// Bubble-sorts a window of an external register file in place, using two read
// ports (data returned one cycle after the address) and one write port.
// Ports:
//   CLK, reset          : rising-edge clock, asynchronous active-high reset
//   start               : sort request, only looked at while idle
//   descending          : sort direction, captured with start
//   from_address, count : window start and length (length clamped to DEPTH)
//   RF_d1, RF_d2        : register-file read data for RF_ad1 / RF_ad2
//   RF_ad1, RF_ad2      : register-file read addresses
//   RF_wa, RF_wd, RF_we : register-file write port
//   busy                : sequencer owns the register-file ports (all non-idle states)
//   done                : single-cycle completion pulse
//   swap_count          : exchanges made by the current or most recent sort
// Each adjacent pair costs ISSUE+CMP, plus WR_LO+WR_HI when it is exchanged.
// A pass that makes no exchange ends the sort early.
module rf_sort_sequencer
    import rf_sort_sequencer_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int WIDTH = RF_WIDTH
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     descending,
    input  logic [$clog2(DEPTH)-1:0] from_address,
    input  logic [LEN_W-1:0]         count,
    input  logic [WIDTH-1:0]         RF_d1,
    input  logic [WIDTH-1:0]         RF_d2,
    output logic [$clog2(DEPTH)-1:0] RF_ad1,
    output logic [$clog2(DEPTH)-1:0] RF_ad2,
    output logic [$clog2(DEPTH)-1:0] RF_wa,
    output logic [WIDTH-1:0]         RF_wd,
    output logic                     RF_we,
    output logic                     busy,
    output logic                     done,
    output logic [SWAPS_W-1:0]       swap_count
);

    localparam int                ADDR_W  = $clog2(DEPTH);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(DEPTH);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pass_q, pass_d;
    logic [ADDR_W-1:0]    j_q, j_d;
    logic                 swapped_q, swapped_d;
    logic [SWAPS_W-1:0]   swaps_q, swaps_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic                 desc_q, desc_d;
    logic [WIDTH-1:0]     hold_d1_q, hold_d1_d;
    logic [WIDTH-1:0]     hold_d2_q, hold_d2_d;

    logic [LEN_W-1:0]     start_len;
    logic [ADDR_W-1:0]    lo_addr;
    logic [ADDR_W-1:0]    hi_addr;
    logic [LEN_W-1:0]     last_j;
    logic                 more_pairs;
    logic                 final_pass;
    logic                 need_swap;
    logic                 advance;

    logic [ADDR_W-1:0]    seq_ad1, seq_ad2, seq_wa;
    logic [WIDTH-1:0]     seq_wd;
    logic                 seq_we;
    logic                 seq_done;

    // Window length after clamping, as it would be captured by a start.
    assign start_len = clamp_len(count, MAX_LEN);

    // Pair addresses wrap naturally in ADDR_W bits, so a window running off
    // the top of the file continues at entry 0.
    assign lo_addr = base_q + j_q;
    assign hi_addr = lo_addr + ADDR_W'(1);

    // Pass p only needs to look at the first len-1-p pairs because the
    // largest (or smallest) value has already bubbled to the end.
    assign last_j     = len_q - LEN_W'(2) - LEN_W'(pass_q);
    assign more_pairs = (LEN_W'(j_q) < last_j);
    assign final_pass = (LEN_W'(pass_q) == (len_q - LEN_W'(2)));

    // The read data arriving during CMP belongs to the pair issued in ISSUE.
    rf_sort_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a         (RF_d1),
        .b         (RF_d2),
        .descending(desc_q),
        .swap      (need_swap)
    );

    // State and datapath registers; everything clears on reset so an
    // interrupted sort leaves no trace besides the partly sorted file.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pass_q    <= '0;
            j_q       <= '0;
            swapped_q <= 1'b0;
            swaps_q   <= '0;
            len_q     <= '0;
            base_q    <= '0;
            desc_q    <= 1'b0;
            hold_d1_q <= '0;
            hold_d2_q <= '0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            j_q       <= j_d;
            swapped_q <= swapped_d;
            swaps_q   <= swaps_d;
            len_q     <= len_d;
            base_q    <= base_d;
            desc_q    <= desc_d;
            hold_d1_q <= hold_d1_d;
            hold_d2_q <= hold_d2_d;
        end
    end

    // Next-state and port decode. The advance step is shared by a CMP that
    // needs no exchange and by WR_HI once the exchange has been written, so
    // it is handled once after the state case.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        j_d       = j_q;
        swapped_d = swapped_q;
        swaps_d   = swaps_q;
        len_d     = len_q;
        base_d    = base_q;
        desc_d    = desc_q;
        hold_d1_d = hold_d1_q;
        hold_d2_d = hold_d2_q;
        advance   = 1'b0;
        seq_ad1   = '0;
        seq_ad2   = '0;
        seq_wa    = '0;
        seq_wd    = '0;
        seq_we    = 1'b0;
        seq_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d  = start_len;
                    base_d = from_address;
                    desc_d = descending;
                    // A window of zero or one entry is already sorted; the
                    // previous swap count is left untouched in that case.
                    if (start_len >= LEN_W'(2)) begin
                        pass_d    = '0;
                        j_d       = '0;
                        swapped_d = 1'b0;
                        swaps_d   = '0;
                        state_d   = ISSUE;
                    end else begin
                        state_d   = DONE;
                    end
                end
            end
            ISSUE: begin
                seq_ad1 = lo_addr;
                seq_ad2 = hi_addr;
                state_d = CMP;
            end
            CMP: begin
                if (need_swap) begin
                    hold_d1_d = RF_d1;
                    hold_d2_d = RF_d2;
                    swapped_d = 1'b1;
                    swaps_d   = swaps_q + SWAPS_W'(1);
                    state_d   = WR_LO;
                end else begin
                    advance   = 1'b1;
                end
            end
            WR_LO: begin
                seq_we  = 1'b1;
                seq_wa  = lo_addr;
                seq_wd  = hold_d2_q;
                state_d = WR_HI;
            end
            WR_HI: begin
                seq_we  = 1'b1;
                seq_wa  = hi_addr;
                seq_wd  = hold_d1_q;
                advance = 1'b1;
            end
            DONE: begin
                seq_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (more_pairs) begin
                j_d     = j_q + ADDR_W'(1);
                state_d = ISSUE;
            end else if (!swapped_q || final_pass) begin
                state_d = DONE;
            end else begin
                pass_d    = pass_q + ADDR_W'(1);
                j_d       = '0;
                swapped_d = 1'b0;
                state_d   = ISSUE;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = seq_done;
    assign swap_count = swaps_q;

    // Register-file port mux: the sequencer drives the ports only while it
    // owns them; otherwise the user-side idle value (all zero) is presented.
    assign RF_ad1 = busy ? seq_ad1 : '0;
    assign RF_ad2 = busy ? seq_ad2 : '0;
    assign RF_wa  = busy ? seq_wa  : '0;
    assign RF_wd  = busy ? seq_wd  : '0;
    assign RF_we  = busy ? seq_we  : 1'b0;

endmodule

// File: tb/tb_rf_sort_sequencer.sv
// tb_rf_sort_sequencer
// Drives the sort sequencer against a small behavioural register file, runs a
// table of directed windows, a batch of random windows checked against a
// bubble-sort reference model, and hand-written reset / restart sequences.
module tb_rf_sort_sequencer;
    import rf_sort_sequencer_pkg::*;

    logic        CLK;
    logic        reset;
    logic        start;
    logic        descending;
    logic [2:0]  from_address;
    logic [3:0]  count;
    logic [3:0]  RF_d1, RF_d2;
    logic [2:0]  RF_ad1, RF_ad2, RF_wa;
    logic [3:0]  RF_wd;
    logic        RF_we;
    logic        busy;
    logic        done;
    logic [4:0]  swap_count;

    logic [7:0][3:0] mem;
    logic [7:0][3:0] load_val;
    logic            load_en;

    int vectors     = 0;
    int miscompares = 0;
    int write_total = 0;
    int stray_total = 0;

    typedef struct {
        string       name;
        logic [31:0] init;
        logic [2:0]  from;
        logic [3:0]  len;
        bit          desc;
        logic [31:0] exp_mem;
        int          exp_swaps;
        int          exp_cycles;
        int          exp_writes;
    } vec_t;

    rf_sort_sequencer #(
        .DEPTH(8),
        .WIDTH(4)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .descending  (descending),
        .from_address(from_address),
        .count       (count),
        .RF_d1       (RF_d1),
        .RF_d2       (RF_d2),
        .RF_ad1      (RF_ad1),
        .RF_ad2      (RF_ad2),
        .RF_wa       (RF_wa),
        .RF_wd       (RF_wd),
        .RF_we       (RF_we),
        .busy        (busy),
        .done        (done),
        .swap_count  (swap_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: registered reads, one write port, plus a bulk load.
    always @(posedge CLK) begin
        RF_d1 <= mem[RF_ad1];
        RF_d2 <= mem[RF_ad2];
        if (load_en) begin
            mem <= load_val;
        end else if (RF_we) begin
            mem[RF_wa] <= RF_wd;
        end
    end

    // Port hygiene monitor: counts writes and any port activity that should
    // be quiet (write fields without enable, addresses while idle/done).
    always @(negedge CLK) begin
        if (RF_we) write_total <= write_total + 1;
        if ((!RF_we && (RF_wa != 3'd0 || RF_wd != 4'd0)) ||
            ((!busy || done) && (RF_ad1 != 3'd0 || RF_ad2 != 3'd0)) ||
            (!busy && (RF_we || done))) begin
            stray_total <= stray_total + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic loadMem(input logic [31:0] value);
        load_val = value;
        load_en  = 1'b1;
        @(posedge CLK);
        #1 load_en = 1'b0;
    endtask

    // Issues a start on the next edge and measures edges from that edge until
    // done is seen, then one more edge to see the block back in idle.
    task automatic applyStimulus(input logic [2:0] from, input logic [3:0] len,
                                 input bit desc, output int cycles,
                                 output logic [2:0] handshake, output int writes,
                                 output int strays);
        int w0;
        int s0;
        w0 = write_total;
        s0 = stray_total;
        from_address = from;
        count        = len;
        descending   = desc;
        start        = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        handshake[2] = busy;
        cycles = 0;
        while (done !== 1'b1 && cycles < 300) begin
            @(posedge CLK);
            #1 cycles++;
        end
        handshake[1] = busy;
        @(posedge CLK);
        #1 handshake[0] = (busy === 1'b0 && done === 1'b0);
        writes = write_total - w0;
        strays = stray_total - s0;
    endtask

    // Reference: plain bubble sort with early exit over the wrapped window;
    // each compare costs 2 cycles and each exchange 2 more.
    task automatic modelSort(input logic [31:0] init, input logic [2:0] from,
                             input logic [3:0] len, input bit desc, input int prev_swaps,
                             output logic [31:0] exp_mem, output int exp_swaps,
                             output int exp_cycles, output int exp_writes);
        logic [7:0][3:0] m;
        int n;
        int w[$];
        int compares;
        int swaps;
        int t;
        bit sw;
        m = init;
        n = (len > 4'd8) ? 8 : int'(len);
        exp_mem = init;
        if (n < 2) begin
            exp_swaps  = prev_swaps;
            exp_cycles = 0;
            exp_writes = 0;
            return;
        end
        for (int k = 0; k < n; k++) w.push_back(int'(m[(int'(from) + k) % 8]));
        compares = 0;
        swaps    = 0;
        for (int p = 0; p < n - 1; p++) begin
            sw = 1'b0;
            for (int k = 0; k < n - 1 - p; k++) begin
                compares++;
                if (desc ? (w[k] < w[k+1]) : (w[k] > w[k+1])) begin
                    t = w[k];
                    w[k] = w[k+1];
                    w[k+1] = t;
                    swaps++;
                    sw = 1'b1;
                end
            end
            if (!sw) break;
        end
        for (int k = 0; k < n; k++) m[(int'(from) + k) % 8] = 4'(w[k]);
        exp_mem    = m;
        exp_swaps  = swaps;
        exp_cycles = 2 * compares + 2 * swaps;
        exp_writes = 2 * swaps;
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] init,
                                input logic [2:0] from, input logic [3:0] len, input bit desc,
                                input logic [31:0] exp_mem, input int exp_swaps,
                                input int exp_cycles, input int exp_writes);
        vec_t v;
        v.name       = name;
        v.init       = init;
        v.from       = from;
        v.len        = len;
        v.desc       = desc;
        v.exp_mem    = exp_mem;
        v.exp_swaps  = exp_swaps;
        v.exp_cycles = exp_cycles;
        v.exp_writes = exp_writes;
        return v;
    endfunction

    task automatic runVector(input vec_t v);
        int cycles;
        int writes;
        int strays;
        logic [2:0] hs;
        loadMem(v.init);
        applyStimulus(v.from, v.len, v.desc, cycles, hs, writes, strays);
        checkOutput({v.name, "_mem"}, mem, v.exp_mem);
        checkOutput({v.name, "_swaps"}, 32'(swap_count), v.exp_swaps);
        checkOutput({v.name, "_cycles"}, cycles, v.exp_cycles);
        checkOutput({v.name, "_writes"}, writes, v.exp_writes);
        checkOutput({v.name, "_stray"}, strays, 0);
        checkOutput({v.name, "_handshake"}, 32'(hs), 32'b111);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t rv;
        int prev_swaps;
        int cycles;
        int writes;
        int strays;
        int k;
        logic [2:0] hs;
        logic [31:0] e_mem;
        int e_swaps, e_cycles, e_writes;
        logic busy_seen;

        reset        = 1'b0;
        start        = 1'b0;
        descending   = 1'b0;
        from_address = 3'd0;
        count        = 4'd0;
        load_en      = 1'b0;
        load_val     = '0;
        #1 reset = 1'b1;
        #1 checkOutput("reset_outputs",
                       32'({RF_ad1, RF_ad2, RF_wa, RF_wd, RF_we, busy, done, swap_count}), 32'd0);
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;

        // Memory words list entry 7 in the top nibble down to entry 0.
        tbl[0] = mk("reversed_asc", 32'h0123_4567, 3'd0, 4'd8,  1'b0, 32'h7654_3210, 28, 112, 56);
        tbl[1] = mk("sorted_asc",   32'h7654_3210, 3'd0, 4'd8,  1'b0, 32'h7654_3210, 0,  14,  0);
        tbl[2] = mk("wrap_desc",    32'h13CB_A902, 3'd6, 4'd4,  1'b1, 32'h23CB_A901, 1,  12,  2);
        tbl[3] = mk("count1",       32'h13CB_A902, 3'd3, 4'd1,  1'b0, 32'h13CB_A902, 1,  0,   0);
        tbl[4] = mk("count0",       32'h0123_4567, 3'd0, 4'd0,  1'b1, 32'h0123_4567, 1,  0,   0);
        tbl[5] = mk("equal555",     32'hFFFF_F555, 3'd0, 4'd3,  1'b0, 32'hFFFF_F555, 0,  4,   0);
        tbl[6] = mk("clamp15",      32'h0123_4567, 3'd0, 4'd15, 1'b0, 32'h7654_3210, 28, 112, 56);

        for (int i = 0; i < 7; i++) runVector(tbl[i]);
        prev_swaps = 28;

        for (int i = 0; i < 25; i++) begin
            rv.name = $sformatf("rand%0d", i);
            rv.init = $urandom();
            rv.from = 3'($urandom_range(0, 7));
            rv.len  = 4'($urandom_range(0, 15));
            rv.desc = 1'($urandom_range(0, 1));
            modelSort(rv.init, rv.from, rv.len, rv.desc, prev_swaps,
                      rv.exp_mem, rv.exp_swaps, rv.exp_cycles, rv.exp_writes);
            runVector(rv);
            prev_swaps = rv.exp_swaps;
        end

        // Reset landing in WR_LO: the pending write never happens.
        loadMem(32'h0123_4567);
        from_address = 3'd0;
        count        = 4'd8;
        descending   = 1'b0;
        start        = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        k = 0;
        while (RF_we !== 1'b1 && k < 20) begin
            @(posedge CLK);
            #1 k++;
        end
        checkOutput("wr_lo_reached", k, 2);
        reset = 1'b1;
        #1 checkOutput("reset_in_wr_lo",
                       32'({RF_we, busy, done, RF_wa, RF_wd, RF_ad1, RF_ad2, swap_count}), 32'd0);
        checkOutput("reset_mem_intact", mem, 32'h0123_4567);
        #1 reset = 1'b0;
        modelSort(32'h0123_4567, 3'd0, 4'd8, 1'b0, 0, e_mem, e_swaps, e_cycles, e_writes);
        applyStimulus(3'd0, 4'd8, 1'b0, cycles, hs, writes, strays);
        checkOutput("post_reset_handshake", 32'(hs), 32'b111);
        checkOutput("post_reset_mem", mem, e_mem);
        checkOutput("post_reset_swaps", 32'(swap_count), e_swaps);
        checkOutput("post_reset_cycles", cycles, e_cycles);

        // A second start while busy must be ignored entirely.
        loadMem(32'hFFFF_F555);
        k = write_total;
        from_address = 3'd0;
        count        = 4'd3;
        descending   = 1'b0;
        start        = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        cycles = 0;
        @(posedge CLK);
        #1 cycles++;
        start        = 1'b1;
        descending   = 1'b1;
        count        = 4'd8;
        from_address = 3'd4;
        @(posedge CLK);
        #1 cycles++;
        start = 1'b0;
        while (done !== 1'b1 && cycles < 300) begin
            @(posedge CLK);
            #1 cycles++;
        end
        checkOutput("midstart_cycles", cycles, 4);
        checkOutput("midstart_swaps", 32'(swap_count), 32'd0);
        busy_seen = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1 busy_seen = busy_seen | busy;
        end
        checkOutput("midstart_no_restart", 32'(busy_seen), 32'd0);
        checkOutput("midstart_writes", write_total - k, 0);
        checkOutput("midstart_mem", mem, 32'hFFFF_F555);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
